// File: rtl/edge_pkg.sv
// Shared types and sizing helpers for the edge generator / detector pair.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package edge_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_LOW, ST_HIGH} fall_st_t;

   // Phase counter width: enough bits to count up to the longer phase minus one.
   function automatic int phase_cnt_w(input int low_cyc, input int high_cyc);
      int longest;
      longest = (low_cyc > high_cyc) ? low_cyc : high_cyc;
      return (longest <= 1) ? 1 : $clog2(longest);
   endfunction

endpackage

// File: rtl/edge_fall_det.sv
// Falling-edge detector: synchronizes din and emits a one-cycle pulse per 1->0 transition.
// Latency: SYNC_STG+1 cycles from din falling to pulse.
// Backpressure: none; every edge separated by at least one sampled cycle is reported.
module edge_fall_det #(
   parameter int SYNC_STG = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic pulse
);

   logic [SYNC_STG-1:0] sync_q, sync_d;
   logic                last_q, last_d;
   logic                pulse_q, pulse_d;

   // Next-state: shift din through the synchronizer and compare against previous level.
   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = din;
      for (int i = 1; i < SYNC_STG; i++) begin
         sync_d[i] = sync_q[i-1];
      end
      last_d  = sync_q[SYNC_STG-1];
      pulse_d = last_q & ~sync_q[SYNC_STG-1];
   end

   // Registers; the line idles high so reset assumes a high history.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '1;
         last_q  <= 1'b1;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         last_q  <= last_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse = pulse_q;

endmodule

// File: rtl/en2falling_gen.sv
// Turns single-cycle enable requests into timed falling edges with min low/high times.
// Latency: en at edge N -> out low at edges N+1..N+LOW_CYC; back-to-back period LOW_CYC+HIGH_CYC.
// Backpressure: none upstream; excess requests queue in a saturating counter, overflow pulses drop.
module en2falling_gen
   import edge_pkg::*;
#(
   parameter int LOW_CYC  = 2,
   parameter int HIGH_CYC = 2,
   parameter int PEND_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   output logic              out,
   output logic              busy,
   output logic [PEND_W-1:0] pend,
   output logic              drop
);

   if (LOW_CYC < 1 || HIGH_CYC < 1 || PEND_W < 1) begin : g_param_chk
      $error("en2falling_gen: LOW_CYC, HIGH_CYC and PEND_W must all be >= 1");
   end

   localparam int                CNT_W     = phase_cnt_w(LOW_CYC, HIGH_CYC);
   localparam logic [CNT_W-1:0]  LOW_LAST  = CNT_W'(LOW_CYC - 1);
   localparam logic [CNT_W-1:0]  HIGH_LAST = CNT_W'(HIGH_CYC - 1);
   localparam logic [PEND_W-1:0] PEND_MAX  = '1;

   fall_st_t          state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic              out_q, out_d;
   logic              busy_q, busy_d;
   logic              drop_q, drop_d;
   logic              req;
   logic              start;

   // State register: phase state and the counter timing the current phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: a new fall may only start from IDLE or on the final HIGH cycle.
   always_comb begin
      req     = en | (pend_q != '0);
      state_d = state_q;
      start   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               state_d = ST_LOW;
               start   = 1'b1;
            end
         end
         ST_LOW: begin
            if (cnt_q == LOW_LAST) begin
               state_d = ST_HIGH;
            end
         end
         ST_HIGH: begin
            if (cnt_q == HIGH_LAST) begin
               if (req) begin
                  state_d = ST_LOW;
                  start   = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Counter restarts on every phase entry and is parked at zero while idle.
      if (state_d != state_q || state_q == ST_IDLE) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Request accounting: a start consumes the oldest queued request, else en itself.
   always_comb begin
      pend_d = pend_q;
      drop_d = 1'b0;
      if (start) begin
         if (!en && pend_q != '0) begin
            pend_d = pend_q - 1'b1;
         end
      end else if (en) begin
         if (pend_q != PEND_MAX) begin
            pend_d = pend_q + 1'b1;
         end else begin
            drop_d = 1'b1;
         end
      end
   end

   // Output decode from the next state so the line changes on the deciding edge.
   always_comb begin
      out_d  = (state_d != ST_LOW);
      busy_d = (state_d != ST_IDLE) || (pend_d != '0);
   end

   // Output and queue registers; reset discards queued requests and releases the line.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q <= '0;
         out_q  <= 1'b1;
         busy_q <= 1'b0;
         drop_q <= 1'b0;
      end else begin
         pend_q <= pend_d;
         out_q  <= out_d;
         busy_q <= busy_d;
         drop_q <= drop_d;
      end
   end

   assign out  = out_q;
   assign busy = busy_q;
   assign pend = pend_q;
   assign drop = drop_q;

endmodule

// File: tb/tb_en2falling_gen.sv
// Bench for en2falling_gen with a loopback falling-edge detector on out.
// Latency: n/a.
// Backpressure: n/a.
module tb_en2falling_gen;

   localparam int LOW_CYC  = 3;
   localparam int HIGH_CYC = 2;
   localparam int PEND_W   = 2;
   localparam int PERIOD   = LOW_CYC + HIGH_CYC;
   localparam int PMAX     = (1 << PEND_W) - 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              en;
   logic              out;
   logic              busy;
   logic [PEND_W-1:0] pend;
   logic              drop;
   logic              det_rst;
   logic              det_pulse;

   always #5 clk = ~clk;

   en2falling_gen #(
      .LOW_CYC (LOW_CYC),
      .HIGH_CYC(HIGH_CYC),
      .PEND_W  (PEND_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .out (out),
      .busy(busy),
      .pend(pend),
      .drop(drop)
   );

   edge_fall_det #(
      .SYNC_STG(1)
   ) det (
      .clk  (clk),
      .rst  (det_rst),
      .din  (out),
      .pulse(det_pulse)
   );

   typedef struct packed {
      logic              out;
      logic              busy;
      logic [PEND_W-1:0] pend;
      logic              drop;
   } obs_t;

   obs_t exp_q[$];
   int   exp_fall_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = -1;
   int   det_cnt  = 0;
   logic prev_out = 1'b1;

   // Reference model: requests are a count; a fall may start once a full period has
   // elapsed since the previous start.
   int m_pend       = 0;
   int m_last_start = -1000;
   int m_starts     = 0;

   function automatic void model_edge(input logic r, input logic e);
      obs_t o;
      bit   start;
      o = '0;
      if (r) begin
         m_pend       = 0;
         m_last_start = -1000;
         o.out        = 1'b1;
      end else begin
         start = (e || m_pend != 0) && (cyc >= m_last_start + PERIOD);
         if (start) begin
            m_last_start = cyc;
            m_starts++;
            exp_fall_q.push_back(cyc);
            if (!e) m_pend--;
         end else if (e) begin
            if (m_pend < PMAX) m_pend++;
            else o.drop = 1'b1;
         end
         o.out  = !(cyc >= m_last_start && cyc < m_last_start + LOW_CYC);
         o.busy = (cyc < m_last_start + PERIOD) || (m_pend != 0);
         o.pend = m_pend[PEND_W-1:0];
      end
      exp_q.push_back(o);
   endfunction

   task automatic step(input logic r, input logic e);
      rst = r;
      en  = e;
      @(posedge clk);
      cyc++;
      model_edge(r, e);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0);
   endtask

   // Monitor: compare registered outputs every cycle and match each observed fall.
   always @(negedge clk) begin
      obs_t ex;
      if (exp_q.size() > 0) begin
         ex = exp_q.pop_front();
         checks += 4;
         if (out !== ex.out) begin
            failures++;
            $display("FAIL out cyc=%0d got=%b exp=%b", cyc, out, ex.out);
         end
         if (busy !== ex.busy) begin
            failures++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, ex.busy);
         end
         if (pend !== ex.pend) begin
            failures++;
            $display("FAIL pend cyc=%0d got=%0d exp=%0d", cyc, pend, ex.pend);
         end
         if (drop !== ex.drop) begin
            failures++;
            $display("FAIL drop cyc=%0d got=%b exp=%b", cyc, drop, ex.drop);
         end
         while (exp_fall_q.size() > 0 && exp_fall_q[0] < cyc) begin
            checks++;
            failures++;
            $display("FAIL missed_fall cyc=%0d expected_at=%0d", cyc, exp_fall_q[0]);
            void'(exp_fall_q.pop_front());
         end
         if (prev_out === 1'b1 && out === 1'b0) begin
            checks++;
            if (exp_fall_q.size() > 0 && exp_fall_q[0] == cyc) begin
               void'(exp_fall_q.pop_front());
            end else begin
               failures++;
               $display("FAIL unexpected_fall got_cyc=%0d exp_cyc=%0d", cyc,
                        (exp_fall_q.size() > 0) ? exp_fall_q[0] : -1);
            end
         end
         prev_out = out;
      end
   end

   always @(negedge clk) begin
      if (det_pulse === 1'b1) det_cnt++;
   end

   initial begin
      int density;
      rst     = 1'b1;
      en      = 1'b0;
      det_rst = 1'b1;
      // Reset for two edges.
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      det_rst = 1'b0;
      idle(8);
      // Single request.
      step(1'b0, 1'b1);
      idle(10);
      // Burst of three.
      repeat (3) step(1'b0, 1'b1);
      idle(20);
      // Saturation: six consecutive requests with a 3-deep queue.
      repeat (6) step(1'b0, 1'b1);
      idle(30);
      // Reset during the low phase with a request queued.
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      idle(15);
      // Request landing on the last HIGH cycle.
      step(1'b0, 1'b1);
      idle(4);
      step(1'b0, 1'b1);
      idle(15);
      // Randomized traffic with varying request density and rare resets.
      density = 4;
      for (int i = 0; i < 3000; i++) begin
         if (i % 50 == 0) density = $urandom_range(1, 7);
         step(($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 7) < density) ? 1'b1 : 1'b0);
      end
      idle(40);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (det_cnt != m_starts) begin
         failures++;
         $display("FAIL detector_count got=%0d exp=%0d", det_cnt, m_starts);
      end
      checks++;
      if (exp_fall_q.size() != 0) begin
         failures++;
         $display("FAIL falls_outstanding got=%0d exp=0", exp_fall_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
